cam_frame_writer: RTL

Camera-side writer for the 80x60 RGB444 frame buffer that the pixel-processing blocks read. It takes a byte stream from an OV7670-style camera (VGA 640x480, RGB444, two bytes per pixel) already sampled into the system clock domain. It decimates the stream 8:1 in both axes, packs each pixel into a 12-bit buffer word, and issues sequential write addresses 0..4799. It signals frame completion so readers can run on a stable image.

---
 rtl/cam_frame_writer_pkg.sv | 38 +++
 rtl/cam_sync_edge.sv | 29 ++
 rtl/cam_frame_writer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cam_frame_writer_pkg.sv
// Shared constants for the 80x60 RGB444 frame buffer.
// Writer and reader blocks agree on geometry, word layout and FSM states.
package cam_frame_writer_pkg;

    localparam int c_cam_cols    = 640;
    localparam int c_cam_rows    = 480;
    localparam int c_dec         = 8;
    localparam int c_img_cols    = c_cam_cols / c_dec;
    localparam int c_img_rows    = c_cam_rows / c_dec;
    localparam int c_img_pxls    = c_img_cols * c_img_rows;
    localparam int c_nb_img_pxls = 13;
    localparam int c_nb_buf      = 12;

    localparam int c_red_msb = 11;
    localparam int c_grn_msb = 7;
    localparam int c_blu_msb = 3;

    typedef enum logic [1:0] {
        S_SYNC,
        S_VBLANK,
        S_ACTIVE,
        S_SKIP
    } state_t;

    function automatic logic [c_nb_buf-1:0] pack_pxl(
        input logic [3:0] r,
        input logic [3:0] g,
        input logic [3:0] b
    );
        logic [c_nb_buf-1:0] p;
        p = '0;
        p[c_red_msb -: 4] = r;
        p[c_grn_msb -: 4] = g;
        p[c_blu_msb -: 4] = b;
        return p;
    endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Registers camera vsync/href and produces single-cycle edge strobes.
module cam_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    input  logic href,
    output logic vs_rise,
    output logic vs_fall,
    output logic hr_fall
);

    logic vsync_q;
    logic href_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
        end else begin
            vsync_q <= vsync;
            href_q  <= href;
        end
    end

    assign vs_rise = vsync & ~vsync_q;
    assign vs_fall = ~vsync & vsync_q;
    assign hr_fall = ~href & href_q;

endmodule

// File: rtl/cam_frame_writer.sv
// Decimates an RGB444 camera byte stream 8:1 per axis into
// sequential frame-buffer writes, flagging complete or short frames.
module cam_frame_writer
    import cam_frame_writer_pkg::*;
#(
    parameter int p_cam_cols = c_cam_cols,
    parameter int p_cam_rows = c_cam_rows
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cap_en,
    input  logic                     vsync,
    input  logic                     href,
    input  logic                     byte_vld,
    input  logic [7:0]               cam_data,
    output logic                     we,
    output logic [c_nb_img_pxls-1:0] wr_addr,
    output logic [c_nb_buf-1:0]      wr_pxl,
    output logic                     frame_done,
    output logic                     frame_err
);

    localparam int c_nb_col = $clog2(p_cam_cols + 1);
    localparam int c_nb_row = $clog2(p_cam_rows + 1);
    localparam int c_nb_dec = $clog2(c_dec);
    localparam int c_pxls   = (p_cam_cols / c_dec) * (p_cam_rows / c_dec);

    localparam logic [c_nb_col-1:0]      c_col_lim  = c_nb_col'(p_cam_cols);
    localparam logic [c_nb_row-1:0]      c_row_lim  = c_nb_row'(p_cam_rows);
    localparam logic [c_nb_img_pxls-1:0] c_addr_lim = c_nb_img_pxls'(c_pxls);

    logic vs_rise;
    logic vs_fall;
    logic hr_fall;

    cam_sync_edge u_sync (
        .clk     (clk),
        .rst     (rst),
        .vsync   (vsync),
        .href    (href),
        .vs_rise (vs_rise),
        .vs_fall (vs_fall),
        .hr_fall (hr_fall)
    );

    state_t                   state;
    logic [c_nb_col-1:0]      col;
    logic [c_nb_row-1:0]      row;
    logic [c_nb_img_pxls-1:0] addr;
    logic                     phase;
    logic [3:0]               red;
    logic                     take;
    logic                     keep;

    assign take = byte_vld & href;

    // Keep only the top-left camera pixel of each 8x8 block.
    assign keep = (col[c_nb_dec-1:0] == '0) &&
                  (row[c_nb_dec-1:0] == '0) &&
                  (col < c_col_lim) &&
                  (row < c_row_lim) &&
                  (addr < c_addr_lim);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_SYNC;
            col        <= '0;
            row        <= '0;
            addr       <= '0;
            phase      <= 1'b0;
            red        <= '0;
            we         <= 1'b0;
            wr_addr    <= '0;
            wr_pxl     <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            we         <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            unique case (state)
                S_SYNC: begin
                    if (vs_rise) state <= S_VBLANK;
                end
                S_VBLANK: begin
                    col   <= '0;
                    row   <= '0;
                    addr  <= '0;
                    phase <= 1'b0;
                    if (vs_fall) state <= cap_en ? S_ACTIVE : S_SKIP;
                end
                S_SKIP: begin
                    if (vs_rise) state <= S_VBLANK;
                end
                S_ACTIVE: begin
                    if (vs_rise) begin
                        frame_done <= (addr == c_addr_lim);
                        frame_err  <= (addr != c_addr_lim);
                        state      <= S_VBLANK;
                    end else if (hr_fall) begin
                        col   <= '0;
                        phase <= 1'b0;
                        if (row < c_row_lim) row <= row + 1'b1;
                    end else if (take) begin
                        if (!phase) begin
                            red   <= cam_data[3:0];
                            phase <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (col < c_col_lim) col <= col + 1'b1;
                            if (keep) begin
                                we      <= 1'b1;
                                wr_addr <= addr;
                                wr_pxl  <= pack_pxl(red, cam_data[7:4],
                                                    cam_data[3:0]);
                                addr    <= addr + 1'b1;
                            end
                        end
                    end
                end
                default: state <= S_SYNC;
            endcase
        end
    end

endmodule
